// File: rtl/counter2_pkg.sv
// Shared encodings and default sizing for the input conditioner.
package counter2_pkg;

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_LOW_PEND  = 2'd1,
    S_HIGH      = 2'd2,
    S_HIGH_PEND = 2'd3
  } cond_state_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_EDGE_CNT_W      = 16;

endpackage

// File: rtl/input_conditioner_sync_ff.sv
// Multi-flop synchronizer chain bringing an asynchronous pin into the clk domain.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;

  always_comb begin
    chain_d = {chain_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q = chain_q[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw pin, emitting a clean level, edge pulses,
// a wrapping rising-edge count and a sticky glitch flag.
module input_conditioner
  import counter2_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int EDGE_CNT_W      = DEF_EDGE_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  raw_in,
  input  logic                  clr_flags,
  output logic                  level_out,
  output logic                  rise_pulse,
  output logic                  fall_pulse,
  output logic [EDGE_CNT_W-1:0] edge_count,
  output logic                  glitch_flag
);

  localparam int QW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [QW-1:0]         Q_ONE   = QW'(1);
  localparam logic [QW-1:0]         Q_LAST  = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [EDGE_CNT_W-1:0] CNT_ONE = EDGE_CNT_W'(1);

  logic sync_q;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (raw_in),
    .q     (sync_q)
  );

  cond_state_e           state_q, state_d;
  logic [QW-1:0]         qcnt_q, qcnt_d;
  logic                  level_q, level_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic [EDGE_CNT_W-1:0] cnt_q, cnt_d;
  logic                  glitch_q, glitch_d;
  logic                  reject;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOW;
      qcnt_q   <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
      glitch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
      glitch_q <= glitch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    cnt_d   = cnt_q;
    reject  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_q) begin
          state_d = S_LOW_PEND;
          qcnt_d  = Q_ONE;
        end else begin
          qcnt_d  = '0;
        end
      end
      S_LOW_PEND: begin
        if (!sync_q) begin
          state_d = S_LOW;
          qcnt_d  = '0;
          reject  = 1'b1;
        end else if (qcnt_q == Q_LAST) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
        end else begin
          qcnt_d  = qcnt_q + Q_ONE;
        end
      end
      S_HIGH: begin
        if (!sync_q) begin
          state_d = S_HIGH_PEND;
          qcnt_d  = Q_ONE;
        end else begin
          qcnt_d  = '0;
        end
      end
      S_HIGH_PEND: begin
        if (sync_q) begin
          state_d = S_HIGH;
          qcnt_d  = '0;
          reject  = 1'b1;
        end else if (qcnt_q == Q_LAST) begin
          state_d = S_LOW;
          qcnt_d  = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          qcnt_d  = qcnt_q + Q_ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        qcnt_d  = '0;
      end
    endcase
    // A rejection in the same cycle as a clear request keeps the flag set.
    glitch_d = reject | (glitch_q & ~clr_flags);
  end

  assign level_out   = level_q;
  assign rise_pulse  = rise_q;
  assign fall_pulse  = fall_q;
  assign edge_count  = cnt_q;
  assign glitch_flag = glitch_q;

endmodule
